// File: rtl/gpio_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gpio_spi_master                                                  |
// | Brief   : SPI mode-0 master that sends 16-bit {rw, addr, data} frames to   |
// |           the GPIO expander. Define GPIO_SPI_MISO_SYNC_EN to add a 2-flop  |
// |           MISO synchroniser.                                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module gpio_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  sclk,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int c_frame_w = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int c_cnt_max = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_bit_w   = $clog2(c_frame_w);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                state_q;
  logic [c_cnt_w-1:0]    cnt_q;
  logic [c_bit_w-1:0]    bit_q;
  logic [c_frame_w-2:0]  tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic                  wr_q;
  logic                  sclk_q;
  logic                  ss_q;
  logic                  mosi_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [c_frame_w-1:0]  w_frame;
  logic                  w_miso;
  logic                  w_div_end;
  logic                  w_sample;

`ifdef GPIO_SPI_MISO_SYNC_EN
  // Synchroniser delay is absorbed by sampling two cycles into the high phase.
  localparam int c_sample = 2;
  logic [1:0] sync_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], miso};
    end
  end

  assign w_miso = sync_q[1];
`else
  localparam int c_sample = 0;
  assign w_miso = miso;
`endif

  assign w_frame   = {req_write, req_addr, req_write ? req_wdata : {DATA_WIDTH{1'b0}}};
  assign w_div_end = (cnt_q == c_cnt_w'(CLK_DIV - 1));
  assign w_sample  = (state_q == S_SHIFT) && sclk_q && (cnt_q == c_cnt_w'(c_sample));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      wr_q        <= 1'b0;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (w_sample) begin
        rx_q <= {rx_q[DATA_WIDTH-2:0], w_miso};
      end
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            tx_q    <= w_frame[c_frame_w-2:0];
            wr_q    <= req_write;
            mosi_q  <= w_frame[c_frame_w-1];
            ss_q    <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == c_bit_w'(c_frame_w - 1)) begin
                state_q <= S_HOLD;
              end else begin
                bit_q  <= bit_q + 1'b1;
                mosi_q <= tx_q[c_frame_w-2];
                tx_q   <= {tx_q[c_frame_w-3:0], 1'b0};
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            cnt_q       <= '0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= wr_q ? {DATA_WIDTH{1'b0}} : rx_q;
            state_q     <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == c_cnt_w'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sclk      = sclk_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire
